// File: rtl/huffman_unpacker.sv
// Bit-stream unpacker: buffers MSB-aligned packed words in a 64-bit FIFO and
// serves variable-length (1..8 bit) code requests with one cycle of latency.
module huffman_unpacker (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] word_in,
  input  logic [5:0]  word_len,
  input  logic        word_valid,
  input  logic        word_last,
  output logic        word_ready,
  input  logic        req_valid,
  input  logic [3:0]  req_len,
  output logic [7:0]  code_out,
  output logic [3:0]  code_len_out,
  output logic        code_valid,
  output logic        underflow,
  output logic        req_error,
  output logic        stream_done,
  output logic [6:0]  bits_avail
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t      state;
  logic [63:0] bit_buf;   // bit 63 is the oldest buffered bit
  logic [6:0]  count;

  logic        last_seen;
  logic        len_ok;
  logic        accept;
  logic        serve;
  logic        starve;
  logic        next_last;
  logic        done;
  logic [6:0]  eff_len;
  logic [6:0]  take;
  logic [6:0]  remain;
  logic [6:0]  next_count;
  logic [31:0] word_mask;
  logic [63:0] appended;
  logic [63:0] next_buf;
  logic [7:0]  code_next;
  state_t      next_state;

  always_comb begin
    last_seen  = (state == DRAIN);
    word_ready = (count <= 7'd32) && !last_seen;
    bits_avail = count;

    len_ok  = (req_len != 4'd0) && (req_len <= 4'd8);
    eff_len = (word_len == 6'd0 || word_len > 6'd32) ? 7'd32 : {1'b0, word_len};
    accept  = ce && word_valid && word_ready;
    serve   = ce && req_valid && len_ok && (count >= {3'b000, req_len});
    starve  = ce && req_valid && len_ok && (count < {3'b000, req_len});

    // Serve first, then append the new word right behind what survives, so
    // a same-cycle request only ever sees pre-load bits.
    take      = serve ? {3'b000, req_len} : 7'd0;
    remain    = count - take;
    word_mask = ~(32'hFFFF_FFFF >> eff_len);
    appended  = {word_in & word_mask, 32'h0000_0000} >> remain;
    next_buf  = (bit_buf << take) | (accept ? appended : 64'd0);
    next_count = remain + (accept ? eff_len : 7'd0);
    code_next  = bit_buf[63:56] >> (4'd8 - req_len);

    next_last = last_seen || (accept && word_last);
    done      = ce && next_last && (next_count == 7'd0);

    next_state = IDLE;
    if (done)
      next_state = IDLE;
    else if (next_last)
      next_state = DRAIN;
    else if (next_count != 7'd0)
      next_state = ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bit_buf      <= 64'd0;
      count        <= 7'd0;
      code_out     <= 8'd0;
      code_len_out <= 4'd0;
      code_valid   <= 1'b0;
      underflow    <= 1'b0;
      req_error    <= 1'b0;
      stream_done  <= 1'b0;
    end else begin
      code_valid  <= serve;
      underflow   <= starve && last_seen;
      req_error   <= ce && req_valid && !len_ok;
      stream_done <= done;
      if (ce) begin
        state   <= next_state;
        bit_buf <= next_buf;
        count   <= next_count;
      end
      if (serve) begin
        code_out     <= code_next;
        code_len_out <= req_len;
      end
    end
  end

endmodule

// File: tb/tb_huffman_unpacker.sv
// Randomized and directed bench for huffman_unpacker against a bit-queue
// reference model of the stream buffer.
module tb_huffman_unpacker;

  logic        clock = 1'b0;
  logic        reset, ce;
  logic [31:0] word_in;
  logic [5:0]  word_len;
  logic        word_valid, word_last, word_ready;
  logic        req_valid;
  logic [3:0]  req_len;
  logic [7:0]  code_out;
  logic [3:0]  code_len_out;
  logic        code_valid, underflow, req_error, stream_done;
  logic [6:0]  bits_avail;

  huffman_unpacker dut (
    .clock(clock), .reset(reset), .ce(ce),
    .word_in(word_in), .word_len(word_len), .word_valid(word_valid),
    .word_last(word_last), .word_ready(word_ready),
    .req_valid(req_valid), .req_len(req_len),
    .code_out(code_out), .code_len_out(code_len_out), .code_valid(code_valid),
    .underflow(underflow), .req_error(req_error), .stream_done(stream_done),
    .bits_avail(bits_avail)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit verbose = 1'b1;

  // Reference model: the buffer is just an ordered queue of bits.
  bit        q[$];
  bit        m_last = 1'b0;
  bit [7:0]  m_code = 8'd0;
  bit [3:0]  m_clen = 4'd0;
  bit        m_cv, m_uf, m_err, m_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit c, input bit wv, input logic [31:0] w,
                      input logic [5:0] wl, input bit wlst, input bit rv, input logic [3:0] rl);
    int el;
    bit rdy;
    reset = rst; ce = c; word_valid = wv; word_in = w; word_len = wl;
    word_last = wlst; req_valid = rv; req_len = rl;

    m_cv = 0; m_uf = 0; m_err = 0; m_done = 0;
    if (rst) begin
      q.delete(); m_last = 0; m_code = 0; m_clen = 0;
    end else if (c) begin
      rdy = (q.size() <= 32) && !m_last;
      el  = (wl == 0 || wl > 32) ? 32 : int'(wl);
      if (rv) begin
        if (rl == 0 || rl > 8) m_err = 1;
        else if (q.size() >= int'(rl)) begin
          m_code = 0;
          for (int k = 0; k < int'(rl); k++) m_code = {m_code[6:0], q.pop_front()};
          m_clen = rl; m_cv = 1;
        end else if (m_last) m_uf = 1;
      end
      if (wv && rdy) begin
        for (int k = 0; k < el; k++) q.push_back(w[31-k]);
        if (wlst) m_last = 1;
      end
      if (m_last && q.size() == 0) begin
        m_done = 1; m_last = 0;
      end
    end

    @(negedge clock);
    check_eq("code_valid", code_valid, m_cv);
    check_eq("underflow", underflow, m_uf);
    check_eq("req_error", req_error, m_err);
    check_eq("stream_done", stream_done, m_done);
    check_eq("code_out", code_out, m_code);
    check_eq("code_len_out", code_len_out, m_clen);
    check_eq("bits_avail", bits_avail, q.size());
    check_eq("word_ready", word_ready, (q.size() <= 32) && !m_last);
    if (verbose)
      $display("txn rst=%0b ce=%0b wv=%0b w=%08h wl=%0d wlast=%0b rv=%0b rl=%0d -> code=%02h len=%0d cv=%0b uf=%0b err=%0b done=%0b avail=%0d rdy=%0b",
               rst, c, wv, w, wl, wlst, rv, rl, code_out, code_len_out, code_valid,
               underflow, req_error, stream_done, bits_avail, word_ready);
  endtask

  task automatic idle_step();
    step(0, 1, 0, 32'h0, 6'd0, 0, 0, 4'd0);
  endtask

  initial begin
    reset = 1; ce = 0; word_in = 0; word_len = 0; word_valid = 0;
    word_last = 0; req_valid = 0; req_len = 0;
    @(negedge clock);
    step(1, 0, 0, 32'h0, 6'd0, 0, 0, 4'd0);
    check_eq("reset_avail", bits_avail, 7'd0);
    check_eq("reset_ready", word_ready, 1'b1);

    // Two 4-bit codes from one 8-bit final word
    step(0, 1, 1, 32'hA500_0000, 6'd8, 1, 0, 4'd0);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd4);
    check_eq("r35_code1", code_out, 8'h0A);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd4);
    check_eq("r35_code2", code_out, 8'h05);
    check_eq("r35_done", stream_done, 1'b1);

    // One code spanning two words
    step(0, 1, 1, 32'hB400_0000, 6'd6, 0, 0, 4'd0);
    step(0, 1, 1, 32'hC000_0000, 6'd2, 1, 0, 4'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0, 1, 4'd8);  // ce low: nothing happens
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd8);
    check_eq("r36_code", code_out, 8'hB7);
    check_eq("r36_len", code_len_out, 4'd8);
    check_eq("r36_done", stream_done, 1'b1);

    // Underflow on an exhausted stream leaves the buffer alone
    step(0, 1, 1, 32'h8000_0000, 6'd1, 1, 0, 4'd0);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd2);
    check_eq("r37_uf", underflow, 1'b1);
    check_eq("r37_avail", bits_avail, 7'd1);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd1);
    check_eq("r37_code", code_out, 8'h01);
    check_eq("r37_done", stream_done, 1'b1);

    // Fill to 64 bits, then back-pressure
    for (int i = 0; i < 3; i++) step(0, 1, 1, $urandom, 6'd32, 0, 0, 4'd0);
    check_eq("r38_full", bits_avail, 7'd64);
    check_eq("r38_ready", word_ready, 1'b0);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd8);
    check_eq("r38_avail", bits_avail, 7'd56);
    check_eq("r38_ready2", word_ready, 1'b0);

    // Simultaneous accept and serve, then a bad request length
    step(1, 1, 0, 32'h0, 6'd0, 0, 0, 4'd0);
    step(0, 1, 1, 32'h3C00_0000, 6'd32, 0, 0, 4'd0);
    step(0, 1, 1, 32'hFFFF_FFFF, 6'd32, 0, 1, 4'd8);
    check_eq("r39_avail", bits_avail, 7'd56);
    check_eq("r39_code", code_out, 8'h3C);
    step(0, 1, 0, 32'h0, 6'd0, 0, 1, 4'd0);
    check_eq("r39_err", req_error, 1'b1);
    check_eq("r39_avail2", bits_avail, 7'd56);

    // Reset wins over a pending accept and request while draining
    step(1, 1, 0, 32'h0, 6'd0, 0, 0, 4'd0);
    step(0, 1, 1, $urandom, 6'd32, 0, 0, 4'd0);
    step(0, 1, 1, $urandom, 6'd8, 1, 0, 4'd0);
    check_eq("r40_avail", bits_avail, 7'd40);
    step(1, 0, 1, $urandom, 6'd8, 0, 1, 4'd4);
    check_eq("r40_avail0", bits_avail, 7'd0);
    check_eq("r40_ready", word_ready, 1'b1);
    check_eq("r40_cv", code_valid, 1'b0);
    check_eq("r40_done", stream_done, 1'b0);

    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rl;
      rl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 1) == 1, $urandom, 6'($urandom_range(0, 63)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
